gemm_seq_ctrl: RTL and testbench
================================

GEMM_SEQ_CTRL -- requirements
Module: gemm_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: loop counter width per dimension.
REQ-002 SHALL have parameter ADDR_W, default 16: operand/result address width.
REQ-003 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1: one-cycle launch pulse from the control register block.
REQ-006 SHALL have ports cfg_m, cfg_k, cfg_n  input  32 each: matrix dimensions, C[MxN] = A[MxK]*B[KxN].
REQ-007 SHALL have port abort  input  1: synchronous cancel of the current job.
REQ-008 SHALL have port op_valid  output  1: MAC operation valid.
REQ-009 SHALL have port op_ready  input  1: MAC datapath accepts operation.
REQ-010 SHALL have ports op_a_addr, op_b_addr, op_c_addr  output  ADDR_W each: A, B and C element addresses of the current operation.
REQ-011 SHALL have ports op_first, op_last  output  1 each: first/last k-step of a C element (accumulator clear / write-back).
REQ-012 SHALL have port pipe_idle  input  1: MAC pipeline empty and all write-backs complete.
REQ-013 SHALL have ports busy, done, err  output  1 each: job active; one-cycle completion pulse; configuration-error flag.
REQ-014 SHALL have port cycle_count  output  32: job cycle count (see Configuration).

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-016 In IDLE, start=1 SHALL latch cfg_m/k/n low CNT_W bits, clear i, j, kk and all addresses, and enter ISSUE next cycle if the configuration is valid.
REQ-017 Configuration SHALL be invalid if any dimension is 0 or has nonzero bits above CNT_W; invalid start SHALL set err=1, stay in IDLE, and issue no operation.
REQ-018 err SHALL hold until the next valid start, which clears it.
REQ-019 In ISSUE, op_valid SHALL be 1 and the op_* outputs SHALL remain stable until op_valid && op_ready.
REQ-020 Loop order SHALL be i (0..M-1) outer, j (0..N-1) middle, kk (0..K-1) inner; each handshake advances kk, wrapping to 0 and incrementing j at K-1; j wraps to 0 and increments i at N-1.
REQ-021 Addresses SHALL be a=i*K+kk, b=kk*N+j, c=i*N+j, computed incrementally with adders (no multipliers), modulo 2^ADDR_W.
REQ-022 op_first SHALL equal (kk==0), and op_last SHALL equal (kk==K-1); for K=1 both SHALL be 1.
REQ-023 The handshake on the operation with i=M-1, j=N-1, kk=K-1 SHALL move to DRAIN; exactly M*N*K handshakes SHALL occur per job.
REQ-024 DRAIN SHALL hold op_valid=0 and move to DONE on the first cycle with pipe_idle=1.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-027 start SHALL be ignored when not in IDLE.
REQ-028 abort=1 in ISSUE or DRAIN SHALL return to IDLE next cycle, with op_valid=0 and busy=0 that cycle, and SHALL NOT pulse done; abort SHALL have priority over a simultaneous handshake.
REQ-029 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-030 On rst_n=0, the block SHALL enter IDLE, and op_valid, op_first, op_last, busy, done, err, all addresses, all counters and cycle_count SHALL be 0.
REQ-031 Reset asserted mid-job SHALL discard the job with no done pulse; after release, the block SHALL wait for a new start.

Configuration
REQ-032 Macro GEMM_SEQ_CYCLE_CNT_EN: when defined, cycle_count SHALL clear on the accepted valid start, increment every cycle while busy (saturating at 2^32-1), and hold after the job ends.
REQ-033 Without GEMM_SEQ_CYCLE_CNT_EN, cycle_count SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-034 Apply M=2,K=3,N=2 with op_ready=1 and pipe_idle=1 -> 12 operations; a sequence 0,1,2,0,1,2,3,4,5,3,4,5; b sequence 0,2,4,1,3,5,0,2,4,1,3,5; c changes 0,1,2,3 on op_last; done one cycle after the last handshake plus DRAIN.
REQ-035 Apply M=1,K=1,N=1 with op_ready low for 3 cycles -> op_valid and op_* stable for 4 cycles; op_first=op_last=1; a=b=c=0; exactly one handshake; one done pulse.
REQ-036 Apply cfg_k=0, then cfg_m=0x10000 with CNT_W=16 -> err=1, busy=0, no op_valid; a subsequent valid start clears err.
REQ-037 Apply M=K=N=4, abort after the 5th handshake -> op_valid=0 next cycle, busy=0, no done; a new start issues again from a=b=c=0.
REQ-038 Hold pipe_idle=0 for 6 cycles after the last handshake -> remain in DRAIN with busy=1; done on the cycle after pipe_idle rises; start pulses during the job are ignored.
REQ-039 With GEMM_SEQ_CYCLE_CNT_EN, M=K=N=2, op_ready=1 and pipe_idle=1 -> cycle_count=10 (8 ISSUE + 1 DRAIN + 1 DONE), held afterward; without the macro, cycle_count=0 throughout.

Source files
------------

// File: rtl/gemm_seq_ctrl.sv
// gemm_seq_ctrl: GEMM loop sequencer issuing MAC operand/result addresses
// for C[MxN] = A[MxK]*B[KxN]. Define GEMM_SEQ_CYCLE_CNT_EN to enable the job
// cycle counter; without it cycle_count is tied to zero.
module gemm_seq_ctrl #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       cfg_m,
  input  logic [31:0]       cfg_k,
  input  logic [31:0]       cfg_n,
  input  logic              abort,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [ADDR_W-1:0] op_a_addr,
  output logic [ADDR_W-1:0] op_b_addr,
  output logic [ADDR_W-1:0] op_c_addr,
  output logic              op_first,
  output logic              op_last,
  input  logic              pipe_idle,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       cycle_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state_q;
  logic [CNT_W-1:0] m_q, k_q, n_q, i_q, j_q, kk_q;
  logic [ADDR_W-1:0] a_q, b_q, c_q, row_q;
  logic valid_q, first_q, last_q, busy_q, done_q, err_q;
  logic cfg_ok, kk_wrap, j_wrap, i_wrap;
  assign cfg_ok  = (cfg_m != 32'd0) && (cfg_k != 32'd0) && (cfg_n != 32'd0) &&
                   (((cfg_m | cfg_k | cfg_n) >> CNT_W) == 32'd0);
  assign kk_wrap = kk_q == k_q - ONE;
  assign j_wrap  = j_q == n_q - ONE;
  assign i_wrap  = i_q == m_q - ONE;
  // Job FSM: row_q holds i*K so a and b can be rebuilt with adders on wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      kk_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          m_q   <= cfg_m[CNT_W-1:0];
          k_q   <= cfg_k[CNT_W-1:0];
          n_q   <= cfg_n[CNT_W-1:0];
          i_q   <= '0;
          j_q   <= '0;
          kk_q  <= '0;
          a_q   <= '0;
          b_q   <= '0;
          c_q   <= '0;
          row_q <= '0;
          if (cfg_ok) begin
            state_q <= ISSUE;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            first_q <= 1'b1;
            last_q  <= cfg_k[CNT_W-1:0] == ONE;
          end else begin
            err_q <= 1'b1;
          end
        end
        ISSUE: if (abort) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end else if (op_ready) begin
          if (kk_wrap) begin
            kk_q    <= '0;
            first_q <= 1'b1;
            last_q  <= k_q == ONE;
            c_q     <= c_q + 1'b1;
            if (j_wrap) begin
              j_q   <= '0;
              i_q   <= i_q + ONE;
              row_q <= row_q + ADDR_W'(k_q);
              a_q   <= row_q + ADDR_W'(k_q);
              b_q   <= '0;
              if (i_wrap) begin
                state_q <= DRAIN;
                valid_q <= 1'b0;
              end
            end else begin
              j_q <= j_q + ONE;
              a_q <= row_q;
              b_q <= ADDR_W'(j_q + ONE);
            end
          end else begin
            kk_q    <= kk_q + ONE;
            a_q     <= a_q + 1'b1;
            b_q     <= b_q + ADDR_W'(n_q);
            first_q <= 1'b0;
            last_q  <= kk_q + ONE == k_q - ONE;
          end
        end
        DRAIN: if (abort) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (pipe_idle) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign op_valid  = valid_q;
  assign op_a_addr = a_q;
  assign op_b_addr = b_q;
  assign op_c_addr = c_q;
  assign op_first  = first_q;
  assign op_last   = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
`ifdef GEMM_SEQ_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  // Cleared by an accepted start, saturating count of busy cycles, held when idle.
  always_comb cyc_d = (state_q == IDLE && start && cfg_ok) ? 32'd0 :
                      (busy_q && ~&cyc_q) ? cyc_q + 32'd1 : cyc_q;
  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else cyc_q <= cyc_d;
  end
  assign cycle_count = cyc_q;
`else
  assign cycle_count = 32'd0;
`endif
endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// tb_gemm_seq_ctrl: scoreboard bench for gemm_seq_ctrl.
module tb_gemm_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic op_ready = 1'b0, pipe_idle = 1'b1;
  logic [31:0] cfg_m = '0, cfg_k = '0, cfg_n = '0;
  logic op_valid, op_first, op_last, busy, done, err;
  logic [15:0] op_a_addr, op_b_addr, op_c_addr;
  logic [31:0] cycle_count;
  int n_vec = 0, n_err = 0, hs_cnt = 0, vcnt = 0, done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] held;
  bit stall_q = 0;

  gemm_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_m(cfg_m), .cfg_k(cfg_k),
    .cfg_n(cfg_n), .abort(abort), .op_valid(op_valid), .op_ready(op_ready),
    .op_a_addr(op_a_addr), .op_b_addr(op_b_addr), .op_c_addr(op_c_addr),
    .op_first(op_first), .op_last(op_last), .pipe_idle(pipe_idle),
    .busy(busy), .done(done), .err(err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: handshakes pop the scoreboard; stalled operations must hold still.
  always @(negedge clk) begin
    if (rst_n) begin
      if (op_valid) vcnt++;
      if (stall_q) chk("stable", {13'd0, op_valid, op_a_addr, op_b_addr, op_c_addr, op_first, op_last}, held);
      if (op_valid && op_ready && !abort) begin
        if (exp_q.size() == 0) chk("extra_op", 1, 0);
        else chk("op", {14'd0, op_a_addr, op_b_addr, op_c_addr, op_first, op_last}, exp_q.pop_front());
        hs_cnt++;
      end
      stall_q = op_valid && !op_ready && !abort;
      held = {13'd0, op_valid, op_a_addr, op_b_addr, op_c_addr, op_first, op_last};
      if (done) done_cnt++;
    end else stall_q = 0;
  end

  task automatic push_job(input int m, input int k, input int n);
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        for (int kk = 0; kk < k; kk++) begin
          logic [15:0] a, b, c;
          a = 16'(i * k + kk);
          b = 16'(kk * n + j);
          c = 16'(i * n + j);
          exp_q.push_back({14'd0, a, b, c, kk == 0, kk == k - 1});
        end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_job(input int m, input int k, input int n, input int lo,
                         input bit rnd, input int hold, input bit spam);
    int hs0, dn0, vc0, cyc, post, last_c;
    bit fin;
    push_job(m, k, n);
    cfg_m = m; cfg_k = k; cfg_n = n;
    op_ready = (lo == 0);
    pipe_idle = (hold == 0);
    hs0 = hs_cnt; dn0 = done_cnt; vc0 = vcnt;
    pulse_start();
    cyc = 0; post = 0; last_c = 0; fin = 0;
    while (!fin && cyc < 3000) begin
      @(negedge clk); #2;
      cyc++;
      if (done) fin = 1;
      else begin
        if (post > 0) begin
          chk("drain_busy", busy, 1);
          chk("drain_valid", op_valid, 0);
        end
        if (hs_cnt - hs0 == m * n * k) begin
          post++;
          if (post == 1) last_c = cyc;
        end
        @(posedge clk); #1;
        op_ready = (cyc < lo) ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pipe_idle = post > hold;
        start = spam & 1'($urandom_range(0, 1));
      end
    end
    chk("done_seen", fin, 1);
    chk("done_latency", cyc, last_c + hold + 2);
    chk("hs_count", hs_cnt - hs0, m * n * k);
    chk("valid_cycles", vcnt - vc0, last_c);
    chk("err_clear", err, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("done_pulse_len", done, 0);
    chk("idle_busy", busy, 0);
    chk("done_count", done_cnt - dn0, 1);
    chk("queue_empty", exp_q.size(), 0);
`ifdef GEMM_SEQ_CYCLE_CNT_EN
    chk("cycle_count", cycle_count, cyc);
    repeat (2) @(negedge clk);
    chk("cycle_count_hold", cycle_count, cyc);
`else
    chk("cycle_count", cycle_count, 0);
`endif
  endtask

  initial begin
    int hs0, dn0, vc0, cnt;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {op_valid, op_first, op_last, busy, done, err}, 0);
    chk("rst_addr", {op_a_addr, op_b_addr, op_c_addr}, 0);
    chk("rst_cycles", cycle_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    // Nominal 2x3x2 job, then a single-op job with a 3-cycle backpressure.
    run_job(2, 3, 2, 0, 0, 0, 0);
    run_job(1, 1, 1, 3, 0, 0, 0);
    // Invalid configurations: K=0, then M above the counter width.
    vc0 = vcnt;
    cfg_m = 2; cfg_k = 0; cfg_n = 2;
    pulse_start();
    @(negedge clk);
    chk("err_k0", {err, busy, op_valid}, 3'b100);
    cfg_m = 32'h10000; cfg_k = 1; cfg_n = 1;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("err_m_wide", {err, busy, op_valid}, 3'b100);
    chk("err_no_ops", vcnt - vc0, 0);
    run_job(2, 2, 2, 0, 1, 0, 0);
    // Abort after the fifth handshake, colliding with a ready sixth op.
    push_job(4, 4, 4);
    cfg_m = 4; cfg_k = 4; cfg_n = 4;
    op_ready = 1'b1; pipe_idle = 1'b1;
    hs0 = hs_cnt; dn0 = done_cnt;
    pulse_start();
    cnt = 0;
    while (hs_cnt - hs0 < 5 && cnt < 200) begin
      @(negedge clk); #2;
      cnt++;
    end
    chk("abort_reach", hs_cnt - hs0, 5);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_state", {op_valid, busy}, 0);
    chk("abort_hs", hs_cnt - hs0, 5);
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt - dn0, 0);
    exp_q.delete();
    // Restart after abort; 2x2x2 also exercises the cycle counter.
    run_job(2, 2, 2, 0, 0, 0, 0);
    // Long drain with start pulses sprinkled through the job.
    run_job(2, 3, 3, 0, 0, 6, 1);
    run_job(3, 2, 3, 0, 1, 0, 0);
    // Reset in the middle of a job.
    push_job(2, 2, 2);
    cfg_m = 2; cfg_k = 2; cfg_n = 2;
    dn0 = done_cnt;
    pulse_start();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_state", {op_valid, busy, done, err}, 0);
    chk("midrst_cycles", cycle_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("midrst_idle", {op_valid, busy}, 0);
    chk("midrst_no_done", done_cnt - dn0, 0);
    run_job(1, 2, 3, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
